// File: rtl/mealy_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mealy_pkg
//  Description : Shared definitions for the 3-state, 2-bit-input Mealy
//                machine: transition/output tables, observer FSM states and
//                candidate-mask helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package mealy_pkg;

   localparam int NUM_STATES = 3;
   localparam int SW_W       = 2;
   localparam int NUM_SW     = 1 << SW_W;

   // Next state, indexed [state][sw]
   localparam logic [1:0] NEXT_TBL [NUM_STATES][NUM_SW] = '{
      '{2'd1, 2'd2, 2'd1, 2'd0},   // S0
      '{2'd2, 2'd2, 2'd2, 2'd0},   // S1
      '{2'd0, 2'd0, 2'd2, 2'd0}    // S2
   };

   // Output bit, indexed [state][sw]
   localparam logic OUT_TBL [NUM_STATES][NUM_SW] = '{
      '{1'b1, 1'b0, 1'b1, 1'b0},   // S0
      '{1'b1, 1'b1, 1'b1, 1'b1},   // S1
      '{1'b1, 1'b1, 1'b0, 1'b0}    // S2
   };

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      LOCKED = 2'd1,
      LOST   = 2'd2
   } obs_state_t;

   // Number of candidates in a mask (0..3)
   function automatic logic [1:0] cand_count(input logic [NUM_STATES-1:0] c);
      return {1'b0, c[0]} + {1'b0, c[1]} + {1'b0, c[2]};
   endfunction

   // Index of the highest set bit; only meaningful for a one-hot mask
   function automatic logic [1:0] cand_index(input logic [NUM_STATES-1:0] c);
      if (c[2])
         return 2'd2;
      else if (c[1])
         return 2'd1;
      else
         return 2'd0;
   endfunction

endpackage : mealy_pkg
`default_nettype wire

// File: rtl/mealy_cand_step.sv
`default_nettype none
// ============================================================================
//  Module      : mealy_cand_step
//  Description : Combinational candidate-set update. Keeps every state whose
//                output for the applied symbol matches the observed bit and
//                maps it through the transition table.
//  Ports       : cand      - current candidate mask
//                sw        - observed input symbol
//                o         - observed output bit
//                cand_next - filtered and advanced candidate mask
//  Revision    : 1.0 - initial release
// ============================================================================
module mealy_cand_step
   import mealy_pkg::*;
(
   input  logic [NUM_STATES-1:0] cand,
   input  logic [SW_W-1:0]       sw,
   input  logic                  o,
   output logic [NUM_STATES-1:0] cand_next
);

   always_comb begin
      cand_next = '0;
      for (int s = 0; s < NUM_STATES; s++) begin
         if (cand[s] && (OUT_TBL[s][sw] == o))
            cand_next[NEXT_TBL[s][sw]] = 1'b1;
      end
   end

endmodule : mealy_cand_step
`default_nettype wire

// File: rtl/mealy_observer.sv
`default_nettype none
// ============================================================================
//  Module      : mealy_observer
//  Description : Passive observer that tracks the set of machine states
//                consistent with the observed (sw, out) stream, reporting
//                lock when one state remains and loss when none remain.
//  Ports       : clk, reset          - clock, sync active-high reset
//                obs_valid           - one observed step this cycle
//                obs_sw, obs_out     - symbol applied / bit produced
//                resync              - restart from the full candidate set
//                cand                - candidate-state mask
//                locked, est_state   - single candidate and its index
//                lost                - no candidate left (sticky)
//                step_cnt            - saturating count of SEARCH observations
//  Revision    : 1.0 - initial release
// ============================================================================
module mealy_observer
   import mealy_pkg::*;
#(
   parameter int CNT_W = 8
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  obs_valid,
   input  logic [SW_W-1:0]       obs_sw,
   input  logic                  obs_out,
   input  logic                  resync,
   output logic [NUM_STATES-1:0] cand,
   output logic                  locked,
   output logic [1:0]            est_state,
   output logic                  lost,
   output logic [CNT_W-1:0]      step_cnt
);

   localparam logic [NUM_STATES-1:0] C_ALL = '1;

   obs_state_t              r_state;
   logic [NUM_STATES-1:0]   w_cand_in;
   logic [NUM_STATES-1:0]   w_cand_next;
   logic [1:0]              w_count;
   logic                    w_accept;

   // A resync restarts the filter from the full set, so a same-cycle
   // observation is judged against every state rather than the old mask.
   assign w_cand_in = resync ? C_ALL : cand;
   assign w_count   = cand_count(w_cand_next);
   assign w_accept  = obs_valid && (resync || (r_state != LOST));

   mealy_cand_step u_step (
      .cand      (w_cand_in),
      .sw        (obs_sw),
      .o         (obs_out),
      .cand_next (w_cand_next)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= SEARCH;
         cand      <= C_ALL;
         locked    <= 1'b0;
         est_state <= 2'd0;
         lost      <= 1'b0;
         step_cnt  <= '0;
      end else if (w_accept) begin
         cand <= w_cand_next;
         case (w_count)
            2'd0: begin
               r_state   <= LOST;
               locked    <= 1'b0;
               est_state <= 2'd0;
               lost      <= 1'b1;
            end
            2'd1: begin
               r_state   <= LOCKED;
               locked    <= 1'b1;
               est_state <= cand_index(w_cand_next);
               lost      <= 1'b0;
            end
            default: begin
               r_state   <= SEARCH;
               locked    <= 1'b0;
               est_state <= 2'd0;
               lost      <= 1'b0;
            end
         endcase
         // Counting restarts at one on a resync step; otherwise only
         // observations taken from SEARCH advance the saturating counter.
         if (resync)
            step_cnt <= CNT_W'(1);
         else if ((r_state == SEARCH) && (step_cnt != '1))
            step_cnt <= step_cnt + CNT_W'(1);
      end else if (resync) begin
         r_state   <= SEARCH;
         cand      <= C_ALL;
         locked    <= 1'b0;
         est_state <= 2'd0;
         lost      <= 1'b0;
         step_cnt  <= '0;
      end
   end

endmodule : mealy_observer
`default_nettype wire

// File: tb/tb_mealy_observer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mealy_observer
//  Description : Self-checking bench for mealy_observer. Two instances share
//                the stimulus: one with an 8-bit counter, one with a 2-bit
//                counter so saturation is exercised. A set-based reference
//                model is updated from the machine's tables.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mealy_observer;

   logic       clk;
   logic       reset;
   logic       obs_valid;
   logic [1:0] obs_sw;
   logic       obs_out;
   logic       resync;

   logic [2:0] cand_a,   cand_b;
   logic       locked_a, locked_b;
   logic [1:0] est_a,    est_b;
   logic       lost_a,   lost_b;
   logic [7:0] cnt_a;
   logic [1:0] cnt_b;

   int checks   = 0;
   int failures = 0;

   // Machine definition: next state and output bit per [state][sw]
   int nxt  [3][4] = '{'{1, 2, 1, 0}, '{2, 2, 2, 0}, '{0, 0, 2, 0}};
   int outb [3][4] = '{'{1, 0, 1, 0}, '{1, 1, 1, 1}, '{1, 1, 0, 0}};

   // Reference model: the set of possible states plus both counters
   bit m_set [3];
   int m_cnt8;
   int m_cnt2;

   mealy_observer #(.CNT_W(8)) dut_a (
      .clk(clk), .reset(reset), .obs_valid(obs_valid), .obs_sw(obs_sw),
      .obs_out(obs_out), .resync(resync), .cand(cand_a), .locked(locked_a),
      .est_state(est_a), .lost(lost_a), .step_cnt(cnt_a)
   );

   mealy_observer #(.CNT_W(2)) dut_b (
      .clk(clk), .reset(reset), .obs_valid(obs_valid), .obs_sw(obs_sw),
      .obs_out(obs_out), .resync(resync), .cand(cand_b), .locked(locked_b),
      .est_state(est_b), .lost(lost_b), .step_cnt(cnt_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
      end
   endtask

   function automatic int set_size();
      int n = 0;
      for (int i = 0; i < 3; i++) if (m_set[i]) n++;
      return n;
   endfunction

   function automatic int set_mask();
      int m = 0;
      for (int i = 0; i < 3; i++) if (m_set[i]) m += (1 << i);
      return m;
   endfunction

   function automatic int set_member();
      int idx = 0;
      for (int i = 0; i < 3; i++) if (m_set[i]) idx = i;
      return idx;
   endfunction

   task automatic model_fill();
      for (int i = 0; i < 3; i++) m_set[i] = 1'b1;
   endtask

   // C' = { next(s,sw) : s in C, out(s,sw) == o }
   task automatic model_filter(input int sw, input int o);
      bit n [3];
      for (int i = 0; i < 3; i++) n[i] = 1'b0;
      for (int s = 0; s < 3; s++)
         if (m_set[s] && outb[s][sw] == o) n[nxt[s][sw]] = 1'b1;
      m_set = n;
   endtask

   task automatic model_update(input bit r, input bit v, input int sw,
                               input int o, input bit rs);
      bit searching;
      if (r) begin
         model_fill();
         m_cnt8 = 0;
         m_cnt2 = 0;
      end else if (rs) begin
         model_fill();
         m_cnt8 = 0;
         m_cnt2 = 0;
         if (v) begin
            model_filter(sw, o);
            m_cnt8 = 1;
            m_cnt2 = 1;
         end
      end else if (v && set_size() != 0) begin
         searching = (set_size() >= 2);
         model_filter(sw, o);
         if (searching) begin
            if (m_cnt8 < 255) m_cnt8++;
            if (m_cnt2 < 3)   m_cnt2++;
         end
      end
   endtask

   task automatic compare_all();
      int n = set_size();
      check_val("cand_a",   cand_a,   set_mask());
      check_val("cand_b",   cand_b,   set_mask());
      check_val("locked_a", locked_a, (n == 1) ? 1 : 0);
      check_val("locked_b", locked_b, (n == 1) ? 1 : 0);
      check_val("est_a",    est_a,    (n == 1) ? set_member() : 0);
      check_val("est_b",    est_b,    (n == 1) ? set_member() : 0);
      check_val("lost_a",   lost_a,   (n == 0) ? 1 : 0);
      check_val("lost_b",   lost_b,   (n == 0) ? 1 : 0);
      check_val("cnt_a",    cnt_a,    m_cnt8);
      check_val("cnt_b",    cnt_b,    m_cnt2);
   endtask

   task automatic step(input bit r, input bit v, input int sw, input int o, input bit rs);
      @(negedge clk);
      reset     = r;
      obs_valid = v;
      obs_sw    = 2'(sw);
      obs_out   = o[0];
      resync    = rs;
      @(posedge clk);
      model_update(r, v, sw, o, rs);
      #1;
      compare_all();
   endtask

   initial begin
      int tstate;
      int sw;
      int o;
      bit v, r, rs;

      reset = 1'b1; obs_valid = 1'b0; obs_sw = 2'd0; obs_out = 1'b0; resync = 1'b0;
      m_cnt8 = 0; m_cnt2 = 0;
      model_fill();

      // Reset values
      step(1, 0, 0, 0, 0);
      check_val("rst_cand", cand_a, 7);
      check_val("rst_cnt",  cnt_a,  0);

      // Single observation locks onto S0
      step(0, 1, 3, 0, 0);
      check_val("tp1_cand", cand_a, 1);
      check_val("tp1_lock", locked_a, 1);
      check_val("tp1_cnt",  cnt_a, 1);

      // Three-step search to lock
      step(1, 0, 0, 0, 0);
      step(0, 1, 0, 1, 0);
      check_val("tp2_c1", cand_a, 7);
      step(0, 1, 2, 1, 0);
      check_val("tp2_c2", cand_a, 6);
      step(0, 1, 3, 1, 0);
      check_val("tp2_c3", cand_a, 1);
      check_val("tp2_cnt", cnt_a, 3);
      check_val("tp2_cnt_sat", cnt_b, 3);

      // Mismatch while locked -> LOST, then observations ignored
      step(0, 1, 3, 1, 0);
      check_val("tp3_lost", lost_a, 1);
      check_val("tp3_cand", cand_a, 0);
      step(0, 1, 0, 1, 0);
      check_val("tp3_hold", cand_a, 0);
      check_val("tp3_cnt",  cnt_a, 3);

      // Resync with same-cycle observation
      step(0, 1, 3, 0, 1);
      check_val("tp4_cand", cand_a, 1);
      check_val("tp4_lost", lost_a, 0);
      check_val("tp4_cnt",  cnt_a, 1);

      // Saturation of the narrow counter
      step(1, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) step(0, 1, 0, 1, 0);
      check_val("tp5_cnt_b", cnt_b, 3);
      check_val("tp5_cnt_a", cnt_a, 5);
      check_val("tp5_lock",  locked_b, 0);

      // Reset in the middle of a burst
      step(0, 1, 2, 1, 0);
      step(1, 1, 3, 1, 0);
      check_val("tp6_cand", cand_a, 7);
      check_val("tp6_cnt",  cnt_a, 0);

      // Randomized run: observations come from a hidden true machine with
      // occasional corrupted output bits to provoke loss.
      tstate = $urandom_range(0, 2);
      for (int i = 0; i < 3000; i++) begin
         r  = ($urandom_range(0, 99) < 2);
         rs = ($urandom_range(0, 99) < 5);
         v  = ($urandom_range(0, 3) != 0);
         sw = $urandom_range(0, 3);
         o  = $urandom_range(0, 1);
         if (r || rs) tstate = $urandom_range(0, 2);
         if (v && !r) begin
            o = outb[tstate][sw];
            if ($urandom_range(0, 39) == 0) o = 1 - o;
            tstate = nxt[tstate][sw];
         end
         step(r, v, sw, o, rs);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_mealy_observer
`default_nettype wire
